// File: rtl/timer_irq_pkg.sv
// timer_irq shared definitions.
// Register map, TCON fields and default base.
package timer_irq_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h4000_0000;

  localparam logic [31:0] TH_OFS   = 32'd0;
  localparam logic [31:0] TL_OFS   = 32'd4;
  localparam logic [31:0] TCON_OFS = 32'd8;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer_irq_if.sv
// timer_irq data-memory bus interface.
// Master is the CPU side, slave the timer.
interface timer_irq_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemRead,
    output MemWrite,
    output Addr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  Addr,
    input  WriteData,
    output ReadData
  );

endinterface

// File: rtl/timer_prescaler.sv
// timer_irq clock prescaler.
// One-cycle tick every PRESCALE enabled cycles.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int W =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // count while enabled, wrap on tick, hold 0 when off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/timer_irq.sv
// timer_irq memory-mapped interval timer.
// TH/TL/TCON registers and the IRQ level.
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  timer_irq_if.slave  bus,
  output logic        IRQ
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;

  logic sel_th;
  logic sel_tl;
  logic sel_tcon;
  logic wr_th;
  logic wr_tl;
  logic wr_tcon;
  logic en;
  logic tick;
  logic ovf;
  logic ovf_set;
  logic [31:0] rdata;

  assign sel_th   = bus.Addr == BASE_ADDR + TH_OFS;
  assign sel_tl   = bus.Addr == BASE_ADDR + TL_OFS;
  assign sel_tcon = bus.Addr == BASE_ADDR + TCON_OFS;

  assign wr_th   = bus.MemWrite && sel_th;
  assign wr_tl   = bus.MemWrite && sel_tl;
  assign wr_tcon = bus.MemWrite && sel_tcon;

  // a write clearing EN zeroes the prescaler this edge
  assign en = tcon[TCON_EN] &&
    !(wr_tcon && !bus.WriteData[TCON_EN]);

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_pre (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  // TL write beats the tick, so no overflow then
  assign ovf     = tick && (tl == TL_MAX) && !wr_tl;
  assign ovf_set = ovf && tcon[TCON_IE];

  // reload register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th <= '0;
    end else if (wr_th) begin
      th <= bus.WriteData;
    end
  end

  // up-counter; reload sees the pre-write TH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tl <= '0;
    end else if (wr_tl) begin
      tl <= bus.WriteData;
    end else if (ovf) begin
      tl <= th;
    end else if (tick) begin
      tl <= tl + 32'd1;
    end
  end

  // control/status; overflow set is never lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcon <= '0;
    end else if (wr_tcon) begin
      tcon[TCON_EN] <= bus.WriteData[TCON_EN];
      tcon[TCON_IE] <= bus.WriteData[TCON_IE];
      tcon[TCON_IS] <= bus.WriteData[TCON_IS] | ovf_set;
    end else if (ovf_set) begin
      tcon[TCON_IS] <= 1'b1;
    end
  end

  // read mux, zero when idle or unmapped
  always_comb begin
    rdata = '0;
    if (bus.MemRead) begin
      unique case (1'b1)
        sel_th:   rdata = th;
        sel_tl:   rdata = tl;
        sel_tcon: rdata = {29'd0, tcon};
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = rdata;
  assign IRQ          = tcon[TCON_IS];

endmodule

// File: tb/tb_timer_irq.sv
// timer_irq bench.
// Directed vectors on PRESCALE=1 and PRESCALE=4.
module tb_timer_irq;
  import timer_irq_pkg::*;

  localparam logic [31:0] B    = DEF_BASE_ADDR;
  localparam logic [31:0] A_TH = B + TH_OFS;
  localparam logic [31:0] A_TL = B + TL_OFS;
  localparam logic [31:0] A_TC = B + TCON_OFS;
  localparam logic [31:0] A_NO = B + 32'd12;

  logic clk = 1'b0;
  logic rst_n;
  logic irq1;
  logic irq4;
  logic [31:0] d;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  timer_irq_if b1 ();
  timer_irq_if b4 ();

  timer_irq #(.BASE_ADDR(B), .PRESCALE(1)) u_t1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b1),
    .IRQ   (irq1)
  );

  timer_irq #(.BASE_ADDR(B), .PRESCALE(4)) u_t4 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b4),
    .IRQ   (irq4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic mr, input logic mw,
                     input logic [31:0] a,
                     input logic [31:0] wd);
    b1.MemRead = mr; b4.MemRead = mr;
    b1.MemWrite = mw; b4.MemWrite = mw;
    b1.Addr = a; b4.Addr = a;
    b1.WriteData = wd; b4.WriteData = wd;
  endtask

  // write lands on the next rising edge
  task automatic wr(input logic [31:0] a,
                    input logic [31:0] wd);
    drv(1'b0, 1'b1, a, wd);
    @(negedge clk);
    drv(1'b0, 1'b0, a, 32'd0);
  endtask

  task automatic rchk(input bit s4, input string tag,
                      input logic [31:0] a,
                      input logic [31:0] exp);
    logic [31:0] v;
    drv(1'b1, 1'b0, a, 32'd0);
    #1;
    v = s4 ? b4.ReadData : b1.ReadData;
    drv(1'b0, 1'b0, a, 32'd0);
    chk(tag, v, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 32'd0, 32'd0);
    #2;
    rchk(0, "rst_th", A_TH, 32'd0);
    chk("rst_irq", {31'd0, irq1}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    rchk(0, "th0", A_TH, 32'd0);
    rchk(0, "tl0", A_TL, 32'd0);
    rchk(0, "tc0", A_TC, 32'd0);
    chk("irq0", {31'd0, irq1}, 32'd0);
    wr(A_TH, 32'h1234_5678);
    rchk(0, "th_rb", A_TH, 32'h1234_5678);
    drv(1'b0, 1'b0, A_TH, 32'd0);
    #1;
    chk("no_rd", b1.ReadData, 32'd0);
    wr(A_NO, 32'hFFFF_FFFF);
    rchk(0, "unmap", A_NO, 32'd0);
    rchk(0, "th_kept", A_TH, 32'h1234_5678);
    cyc(1);

    // basic overflow at PRESCALE=1
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFC);
    wr(A_TC, 32'd3);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      chk($sformatf("pre_irq%0d", k),
          {31'd0, irq1}, 32'd0);
    end
    cyc(1);
    chk("ovf_irq", {31'd0, irq1}, 32'd1);
    rchk(0, "ovf_tl", A_TL, 32'hFFFF_FFFC);
    rchk(0, "ovf_tc", A_TC, 32'd7);

    // clear status, fires again one period later
    wr(A_TC, 32'd3);
    chk("clr_irq", {31'd0, irq1}, 32'd0);
    cyc(2);
    chk("clr_hold", {31'd0, irq1}, 32'd0);
    cyc(1);
    chk("refire", {31'd0, irq1}, 32'd1);

    // clear collides with overflow
    wr(A_TC, 32'd3);
    chk("clr2", {31'd0, irq1}, 32'd0);
    cyc(2);
    rchk(0, "tl_ff", A_TL, 32'hFFFF_FFFF);
    wr(A_TC, 32'd3);
    rchk(0, "coll_tc", A_TC, 32'd7);
    chk("coll_irq", {31'd0, irq1}, 32'd1);

    // overflow with interrupts disabled
    wr(A_TC, 32'd0);
    chk("off_irq", {31'd0, irq1}, 32'd0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h0000_0100);
    wr(A_TC, 32'd1);
    rchk(0, "ie0_pre", A_TL, 32'hFFFF_FFFF);
    cyc(1);
    rchk(0, "ie0_rld", A_TL, 32'h0000_0100);
    chk("ie0_irq", {31'd0, irq1}, 32'd0);
    rchk(0, "ie0_tc", A_TC, 32'd1);
    cyc(1);
    rchk(0, "ie0_inc", A_TL, 32'h0000_0101);

    // asynchronous reset mid-count
    #1 rst_n = 1'b0;
    rchk(0, "mr_tl", A_TL, 32'd0);
    rchk(0, "mr_tc", A_TC, 32'd0);
    chk("mr_irq", {31'd0, irq1}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    rchk(0, "mr_idle", A_TL, 32'd0);
    rchk(1, "p4_tl0", A_TL, 32'd0);

    // PRESCALE=4 counting
    wr(A_TL, 32'd0);
    wr(A_TC, 32'd1);
    cyc(11);
    rchk(1, "p4_11", A_TL, 32'd2);
    cyc(1);
    rchk(1, "p4_12", A_TL, 32'd3);
    wr(A_TC, 32'd0);
    cyc(8);
    rchk(1, "p4_frz", A_TL, 32'd3);
    rchk(1, "p4_tc", A_TC, 32'd0);
    chk("p4_irq", {31'd0, irq4}, 32'd0);

    // TL write on a tick edge wins
    wr(A_TC, 32'd1);
    cyc(3);
    wr(A_TL, 32'h0000_0050);
    rchk(1, "p4_wr", A_TL, 32'h0000_0050);
    cyc(3);
    rchk(1, "p4_hold", A_TL, 32'h0000_0050);
    cyc(1);
    rchk(1, "p4_next", A_TL, 32'h0000_0051);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
